// File: rtl/sample_playback_src.sv
// -----------------------------------------------------------------------------
// sample_playback_src
//
// Purpose: holds a window of samples in a small block RAM and plays them out
// as a paced stream (one sample every rate_div+1 cycles), single-shot or
// looping, with start/stop control and an end-of-pass pulse.
//
// Configuration macro: SAMPLE_PLAYBACK_LOOP_EN
//   defined   -> loop_en repeats the pass until stop
//   undefined -> loop_en is ignored, every pass is single-shot
//
// Ports:
//   clk        in   1            single clock, posedge
//   reset      in   1            synchronous, active-low
//   wr_en      in   1            RAM load strobe (accepted in any state)
//   wr_addr    in   AW           RAM load address
//   wr_data    in   DATA_WIDTH   RAM load data
//   start      in   1            playback start request (honoured in IDLE)
//   stop       in   1            playback abort request
//   length     in   AW+1         samples per pass (clamped to WIND_DEPTH)
//   rate_div   in   8            idle cycles between samples
//   loop_en    in   1            repeat playback
//   x_N        out  DATA_WIDTH   sample stream, holds value between pulses
//   x_N_valid  out  1            one-cycle sample qualifier
//   busy       out  1            playback in progress
//   done       out  1            pulse with the last sample of each pass
// -----------------------------------------------------------------------------
module sample_playback_src #(
    parameter int DATA_WIDTH = 16,
    parameter int WIND_DEPTH = 16,
    localparam int AW = (WIND_DEPTH > 1) ? $clog2(WIND_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic [AW:0]           length,
    input  logic [7:0]            rate_div,
    input  logic                  loop_en,
    output logic [DATA_WIDTH-1:0] x_N,
    output logic                  x_N_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(WIND_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [WIND_DEPTH];

    state_t                r_state;
    logic [AW-1:0]         r_addr;
    logic [AW:0]           r_len;
    logic [7:0]            r_rate;
    logic                  r_loop;
    logic [7:0]            r_wait;
    logic [DATA_WIDTH-1:0] r_x_n;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_next_state;
    logic [AW:0]           w_eff_len;
    logic                  w_loop_in;
    logic                  w_last_addr;
    logic                  w_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

`ifdef SAMPLE_PLAYBACK_LOOP_EN
    assign w_loop_in = loop_en;
`else
    assign w_loop_in = loop_en & 1'b0;
`endif

    // Clamp the requested pass length to the RAM depth and flag the final address.
    always_comb begin
        w_eff_len   = length;
        w_last_addr = 1'b0;
        if (length > DEPTH_L) begin
            w_eff_len = DEPTH_L;
        end else begin
            w_eff_len = length;
        end
        // r_len is never zero while playing, so the subtraction cannot wrap into a match
        if ({1'b0, r_addr} == (r_len - (AW+1)'(1))) begin
            w_last_addr = 1'b1;
        end else begin
            w_last_addr = 1'b0;
        end
    end

    // Next-state logic; stop overrides everything else.
    always_comb begin
        w_next_state = r_state;
        if (stop) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (w_eff_len != '0)) begin
                        w_next_state = S_PRIME;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_PRIME: begin
                    w_next_state = S_RUN;
                end
                S_RUN: begin
                    // r_done is high exactly in the RUN cycle showing the last sample
                    if (r_done && !r_loop) begin
                        w_next_state = S_IDLE;
                    end else if (r_rate == 8'd0) begin
                        w_next_state = S_RUN;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait <= 8'd1) begin
                        w_next_state = S_RUN;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state; the results are registered below.
    always_comb begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        if (w_next_state == S_RUN) begin
            w_valid_nxt = 1'b1;
            w_done_nxt  = w_last_addr;
        end else begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b0;
        end
        if (w_next_state != S_IDLE) begin
            w_busy_nxt = 1'b1;
        end else begin
            w_busy_nxt = 1'b0;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // State, pass parameters, read address and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_rate  <= 8'd0;
            r_loop  <= 1'b0;
            r_wait  <= 8'd0;
            r_x_n   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Pass parameters are frozen at the moment the start is accepted
            if ((r_state == S_IDLE) && (w_next_state == S_PRIME)) begin
                r_len  <= w_eff_len;
                r_rate <= rate_div;
                r_loop <= w_loop_in;
            end

            if ((r_state == S_RUN) && (w_next_state == S_WAIT)) begin
                r_wait <= r_rate;
            end else if (r_state == S_WAIT) begin
                r_wait <= r_wait - 8'd1;
            end

            // Synchronous read: the RAM output register is x_N itself, loaded
            // only when a sample is emitted so it holds between pulses. A write
            // to the same address on this edge is not yet visible (read-first).
            if (w_next_state == S_RUN) begin
                r_x_n  <= r_mem[r_addr];
                r_addr <= w_last_addr ? '0 : (r_addr + AW'(1));
            end else if (w_next_state == S_IDLE) begin
                r_addr <= '0;
            end

            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign x_N       = r_x_n;
    assign x_N_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sample_playback_src.sv
module tb_sample_playback_src;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        stop;
    logic [4:0]  length;
    logic [7:0]  rate_div;
    logic        loop_en;
    logic [15:0] x_N;
    logic        x_N_valid;
    logic        busy;
    logic        done;

    int          n_err;
    int          n_checks;
    logic [15:0] mem_model [16];
    logic [15:0] exp_x;

    sample_playback_src #(.DATA_WIDTH(16), .WIND_DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .length    (length),
        .rate_div  (rate_div),
        .loop_en   (loop_en),
        .x_N       (x_N),
        .x_N_valid (x_N_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[3:0];
        wr_data = d;
        mem_model[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // One playback: start issued in cycle T (offset 0), outputs checked for
    // offsets 1..ncyc. Sample k is expected at offset 2+k*(rd+1); the RAM read
    // for it happens at the end of offset 1+k*(rd+1). abort_at>0 issues stop
    // (or reset when abort_rst) in that offset.
    task automatic run_pass(input string tag, input int len, input int rd, input int lp,
                            input int ncyc, input int abort_at, input int abort_rst,
                            input int wr_rand);
        int          eff;
        int          exp_loop;
        int          total;
        int          k;
        int          ra;
        logic        ev;
        logic        eb;
        logic        ed;
        logic        aborted;
        logic [15:0] nxt_exp;
        eff = (len > 16) ? 16 : len;
`ifdef SAMPLE_PLAYBACK_LOOP_EN
        exp_loop = lp;
`else
        exp_loop = 0;
`endif
        total   = (exp_loop != 0) ? 32'h4000_0000 : eff;
        nxt_exp = 16'h0;
        @(negedge clk);
        length   = len[4:0];
        rate_div = rd[7:0];
        loop_en  = lp[0];
        start    = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            wr_en = 1'b0;
            start = 1'b0;
            if (c == 1) begin
                // later parameter changes must not affect the running pass
                length   = 5'($urandom_range(0, 31));
                rate_div = 8'($urandom_range(0, 255));
                loop_en  = 1'($urandom_range(0, 1));
            end
            aborted = (abort_at > 0) && (c > abort_at);
            ev = 1'b0;
            eb = 1'b0;
            ed = 1'b0;
            if ((eff != 0) && !aborted) begin
                eb = (exp_loop != 0) || (c <= 2 + (eff - 1) * (rd + 1));
                if ((c >= 2) && (((c - 2) % (rd + 1)) == 0)) begin
                    k  = (c - 2) / (rd + 1);
                    ev = (k < total);
                    ed = ev && ((k % eff) == eff - 1);
                end
            end
            if (ev) exp_x = nxt_exp;
            if (aborted && (abort_rst != 0)) exp_x = 16'h0;
            chk({tag, "_valid"}, {31'b0, x_N_valid}, {31'b0, ev});
            chk({tag, "_busy"},  {31'b0, busy},      {31'b0, eb});
            chk({tag, "_done"},  {31'b0, done},      {31'b0, ed});
            chk({tag, "_data"},  {16'b0, x_N},       {16'b0, exp_x});
            if (c == abort_at) begin
                if (abort_rst != 0) reset = 1'b0;
                else stop = 1'b1;
            end
            if ((abort_at > 0) && (c == abort_at + 1)) begin
                reset = 1'b1;
                stop  = 1'b0;
            end
            ra = 0;
            if ((eff != 0) && (((c - 1) % (rd + 1)) == 0) && (((c - 1) / (rd + 1)) < total)) begin
                ra      = ((c - 1) / (rd + 1)) % eff;
                nxt_exp = mem_model[ra];
            end
            if ((wr_rand != 0) && ($urandom_range(0, 1) == 1)) begin
                wr_en   = 1'b1;
                wr_addr = ($urandom_range(0, 1) == 1) ? ra[3:0] : 4'($urandom_range(0, 15));
                wr_data = 16'($urandom);
                mem_model[wr_addr] = wr_data;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        stop  = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        int len;
        int rd;
        int lp;
        int eff;
        int ncyc;
        n_err    = 0;
        n_checks = 0;
        exp_x    = 16'h0;
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 4'h0;
        wr_data  = 16'h0;
        start    = 1'b0;
        stop     = 1'b0;
        length   = 5'd0;
        rate_div = 8'd0;
        loop_en  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, x_N_valid}, 32'd0);
        chk("rst_busy",  {31'b0, busy},      32'd0);
        chk("rst_done",  {31'b0, done},      32'd0);
        chk("rst_data",  {16'b0, x_N},       32'd0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) load(i, 16'h0100 + 16'(i));

        run_pass("basic4",   4,  0, 0,  8, 0,  0, 0);
        run_pass("rate2",    3,  2, 0, 14, 0,  0, 0);
        run_pass("loop2",    2,  0, 1, 11, 9,  0, 0);
        run_pass("len0",     0,  0, 0,  5, 0,  0, 0);
        run_pass("len31",   31,  0, 0, 21, 0,  0, 0);
        run_pass("rstmid",   8,  0, 0,  8, 3,  1, 0);
        run_pass("replay",   4,  0, 0,  8, 0,  0, 0);
        run_pass("loopwait", 3,  1, 1, 15, 12, 0, 0);
        run_pass("wrcoll",   6,  0, 0, 10, 0,  0, 1);

        for (int r = 0; r < 8; r++) begin
            len  = $urandom_range(1, 20);
            rd   = $urandom_range(0, 4);
            lp   = $urandom_range(0, 1);
            eff  = (len > 16) ? 16 : len;
            ncyc = 2 + (eff - 1) * (rd + 1) + 3;
            if (lp != 0) run_pass("rnd", len, rd, lp, ncyc + 6, ncyc + 3, 0, 1);
            else         run_pass("rnd", len, rd, lp, ncyc, 0, 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_playback_src.md
SAMPLE_PLAYBACK_SRC -- requirements
Module: sample_playback_src

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-002 SHALL have parameter WIND_DEPTH, default 16, playback RAM depth in samples; AW = $clog2(WIND_DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1, RAM load strobe.
REQ-006 SHALL have port wr_addr, input, AW, RAM load address.
REQ-007 SHALL have port wr_data, input, DATA_WIDTH, RAM load data.
REQ-008 SHALL have port start, input, 1, playback start request.
REQ-009 SHALL have port stop, input, 1, playback abort request.
REQ-010 SHALL have port length, input, AW+1, number of samples per pass.
REQ-011 SHALL have port rate_div, input, 8, idle cycles between samples.
REQ-012 SHALL have port loop_en, input, 1, repeat playback.
REQ-013 SHALL have port x_N, output, DATA_WIDTH, sample stream to the filter.
REQ-014 SHALL have port x_N_valid, output, 1, one-cycle sample qualifier; no backpressure.
REQ-015 SHALL have port busy, output, 1, playback in progress.
REQ-016 SHALL have port done, output, 1, one-cycle end-of-pass pulse.

Function
REQ-017 SHALL store samples in a single-port-per-side block RAM: synchronous write on wr_en, synchronous read, one-cycle read latency, read-first on same-address collision.
REQ-018 SHALL implement FSM states IDLE, PRIME, RUN, WAIT.
REQ-019 SHALL go IDLE->PRIME when start=1 and effective length != 0; start in any other state SHALL be ignored.
REQ-020 SHALL use effective length = min(length, WIND_DEPTH), captured at start; later length changes SHALL not affect the pass.
REQ-021 SHALL capture rate_div and loop_en at start.
REQ-022 SHALL, with start sampled in cycle T, present address 0 in PRIME and assert x_N_valid with mem[0] in cycle T+2.
REQ-023 SHALL space consecutive x_N_valid pulses exactly rate_div+1 cycles apart (RUN, then rate_div cycles in WAIT); rate_div=0 yields one sample per cycle.
REQ-024 SHALL output samples in address order 0..effective length-1.
REQ-025 SHALL assert done in the same cycle as x_N_valid for the last sample of each pass.
REQ-026 SHALL, with loop on, wrap to address 0 after the last sample with unchanged spacing and remain busy; otherwise return to IDLE the cycle after the last sample.
REQ-027 SHALL, on stop sampled in cycle T in any non-IDLE state, deassert x_N_valid and busy from T+1, suppress done, go IDLE; stop has priority over start in the same cycle.
REQ-028 SHALL assert busy in every non-IDLE state.
REQ-029 SHALL hold x_N at the last output value while x_N_valid=0.
REQ-030 SHALL accept RAM writes in any state; a write to the address being read SHALL yield the old data.

Reset
REQ-031 SHALL, while reset=0, force state IDLE, read address 0, x_N=0, x_N_valid=0, busy=0, done=0; RAM contents not cleared.
REQ-032 SHALL, on reset mid-playback, abort with no further x_N_valid or done.

Configuration
REQ-033 SHALL honour macro SAMPLE_PLAYBACK_LOOP_EN: defined -> loop_en behaves per REQ-026; undefined -> loop_en ignored, every pass single-shot.

Verification
REQ-034 SHALL cover: load mem[i]=i+0x100 for i=0..15, length=4, rate_div=0, start at T -> x_N_valid T+2..T+5, data 0x100..0x103, done at T+5, busy low T+6.
REQ-035 SHALL cover: length=3, rate_div=2 -> valid pulses 3 cycles apart, three samples, one done.
REQ-036 SHALL cover: length=2, loop_en=1 (macro defined), rate_div=0 -> 0x100,0x101,0x100,0x101... continuous, done every second sample; stop -> valid low next cycle, no done.
REQ-037 SHALL cover: length=0 start -> busy stays 0; length=31 -> exactly 16 samples.
REQ-038 SHALL cover: reset=0 during RUN after 2 samples -> all outputs 0 next cycle; start after release replays from address 0.
REQ-039 SHALL cover: macro undefined, loop_en=1, length=2 -> exactly two samples, then IDLE.
